// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with call/return stack and sticky fault trap; all effects land one cycle after the request.
// Build with PC_BOUND_CHECK_EN to trap increments, branches and call return addresses that leave the address range.
module program_counter_stack #(
  parameter int                 ADDR_W      = 8,
  parameter int                 OFFSET_W    = 8,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic                branch,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                jump,
  input  logic                call,
  input  logic                ret,
  input  logic [ADDR_W-1:0]   target,
  output logic [ADDR_W-1:0]   addr,
  output logic                stack_empty,
  output logic                stack_full,
  output logic                fault
);

  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic              fault_q, fault_d;
  logic              empty_q, full_q;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic              push;
  logic [IDX_W-1:0]  push_idx, top_idx;
  logic [ADDR_W-1:0] inc_next;
  logic [ADDR_W-1:0] br_next;

`ifdef PC_BOUND_CHECK_EN
  // Two extra bits hold the carry and the sign of the true branch result.
  logic [ADDR_W:0]   inc_wide;
  logic [ADDR_W+1:0] off_wide, br_wide;
  logic              inc_oob, br_oob;

  always_comb begin
    inc_wide = {1'b0, addr_q} + (ADDR_W+1)'(1);
    off_wide = (ADDR_W+2)'($signed(offset));
    br_wide  = {2'b00, addr_q} + off_wide;
    inc_next = inc_wide[ADDR_W-1:0];
    br_next  = br_wide[ADDR_W-1:0];
    inc_oob  = inc_wide[ADDR_W];
    br_oob   = br_wide[ADDR_W+1] | br_wide[ADDR_W];
  end
`else
  logic [ADDR_W-1:0] off_ext;

  always_comb begin
    off_ext  = ADDR_W'($signed(offset));
    inc_next = addr_q + ADDR_W'(1);
    br_next  = addr_q + off_ext;
  end
`endif

  assign push_idx = IDX_W'(sp_q);
  assign top_idx  = IDX_W'(sp_q - PTR_W'(1));

  always_comb begin
    addr_d  = addr_q;
    sp_d    = sp_q;
    fault_d = fault_q;
    push    = 1'b0;
    // A latched fault freezes everything until reset.
    if (!fault_q && !halt) begin
      if (ret) begin
        if (sp_q == '0) begin
          fault_d = 1'b1;
        end else begin
          addr_d = stack_q[top_idx];
          sp_d   = sp_q - PTR_W'(1);
        end
      end else if (call) begin
        if (sp_q == DEPTH_P) begin
          fault_d = 1'b1;
`ifdef PC_BOUND_CHECK_EN
        end else if (inc_oob) begin
          fault_d = 1'b1;
`endif
        end else begin
          push   = 1'b1;
          addr_d = target;
          sp_d   = sp_q + PTR_W'(1);
        end
      end else if (jump) begin
        addr_d = target;
      end else if (branch) begin
`ifdef PC_BOUND_CHECK_EN
        if (br_oob) fault_d = 1'b1;
        else        addr_d  = br_next;
`else
        addr_d = br_next;
`endif
      end else begin
`ifdef PC_BOUND_CHECK_EN
        if (inc_oob) fault_d = 1'b1;
        else         addr_d  = inc_next;
`else
        addr_d = inc_next;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= RESET_ADDR;
      sp_q    <= '0;
      fault_q <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
      empty_q <= (sp_d == '0);
      full_q  <= (sp_d == DEPTH_P);
    end
  end

  // Stack contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (push && !reset) stack_q[push_idx] <= inc_next;
  end

  assign addr        = addr_q;
  assign stack_empty = empty_q;
  assign stack_full  = full_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack with hand-computed expectations; adapts to PC_BOUND_CHECK_EN.
module tb_program_counter_stack;

`ifdef PC_BOUND_CHECK_EN
  localparam bit BOUND = 1'b1;
`else
  localparam bit BOUND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, halt, branch, jump, call, ret;
  logic [7:0] offset, target;
  logic [7:0] addr;
  logic       stack_empty, stack_full, fault;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  program_counter_stack #(
    .ADDR_W(8), .OFFSET_W(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .halt(halt), .branch(branch), .offset(offset),
    .jump(jump), .call(call), .ret(ret), .target(target), .addr(addr),
    .stack_empty(stack_empty), .stack_full(stack_full), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; branch = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    offset = 8'h00; target = 8'h00;
    step(); step();
    check("rst_addr", addr, 0);
    check("rst_empty", stack_empty, 1);
    check("rst_full", stack_full, 0);
    check("rst_fault", fault, 0);
    reset = 1'b0;

    for (int i = 1; i <= 5; i++) begin
      step();
      check("inc_run", addr, i);
    end
    check("inc_empty", stack_empty, 1);
    check("inc_fault", fault, 0);

    branch = 1'b1; offset = 8'd20; step(); check("br_fwd", addr, 25);
    branch = 1'b0; step(); check("br_inc", addr, 26);
    branch = 1'b1; offset = 8'hF6; step(); check("br_back", addr, 16);
    branch = 1'b0;

    call = 1'b1; target = 8'h40; step();
    check("call1", addr, 8'h40); check("call1_empty", stack_empty, 0);
    target = 8'h80; step(); check("call2", addr, 8'h80);
    call = 1'b0; ret = 1'b1; step(); check("ret1", addr, 8'h41);
    step(); check("ret2", addr, 8'h11); check("ret2_empty", stack_empty, 1);
    ret = 1'b0;

    // ret beats call in the same cycle
    call = 1'b1; target = 8'h20; step(); check("call3", addr, 8'h20);
    ret = 1'b1; target = 8'h99; step();
    check("callret_addr", addr, 8'h12); check("callret_empty", stack_empty, 1);
    check("callret_fault", fault, 0);
    call = 1'b0; ret = 1'b0;

    jump = 1'b1; branch = 1'b1; target = 8'h30; offset = 8'd5; step();
    check("jump_over_br", addr, 8'h30);
    jump = 1'b0; branch = 1'b0; step(); check("jump_inc", addr, 8'h31);

    call = 1'b1;
    for (int i = 0; i < 4; i++) begin
      target = 8'hA0 + 8'(i);
      step();
      check("fill_call", addr, 8'hA0 + i);
    end
    check("fill_full", stack_full, 1); check("fill_fault", fault, 0);
    target = 8'hA4; step();
    check("ovf_addr", addr, 8'hA3); check("ovf_fault", fault, 1); check("ovf_full", stack_full, 1);
    call = 1'b0;

    branch = 1'b1; offset = 8'd3; ret = 1'b1; step();
    check("frozen_addr", addr, 8'hA3); check("frozen_fault", fault, 1);
    branch = 1'b0; ret = 1'b0;
    halt = 1'b1; step(); halt = 1'b0; step();
    check("frozen_halt_rel", addr, 8'hA3);

    reset = 1'b1; call = 1'b1; target = 8'h55; step();
    check("rst2_addr", addr, 0); check("rst2_fault", fault, 0);
    check("rst2_empty", stack_empty, 1); check("rst2_full", stack_full, 0);
    reset = 1'b0; call = 1'b0;

    jump = 1'b1; target = 8'h07; step(); check("jump7", addr, 7);
    jump = 1'b0; ret = 1'b1; step();
    check("unf_addr", addr, 7); check("unf_fault", fault, 1);
    ret = 1'b0; halt = 1'b1; step(); halt = 1'b0; step();
    check("unf_frozen", addr, 7);

    do_reset();
    halt = 1'b1; branch = 1'b1; offset = 8'd5; step(); check("halt1", addr, 0);
    step(); check("halt2", addr, 0);
    halt = 1'b0; branch = 1'b0; step(); check("resume1", addr, 1);
    step(); check("resume2", addr, 2);

    jump = 1'b1; target = 8'hFF; step(); check("jump_max", addr, 8'hFF);
    jump = 1'b0; step();
    check("max_inc", addr, BOUND ? 8'hFF : 8'h00);
    check("max_inc_fault", fault, BOUND ? 1 : 0);

    do_reset();
    jump = 1'b1; target = 8'hFF; step(); jump = 1'b0;
    call = 1'b1; target = 8'h10; step();
    check("max_call", addr, BOUND ? 8'hFF : 8'h10);
    check("max_call_fault", fault, BOUND ? 1 : 0);
    call = 1'b0; ret = 1'b1; step();
    check("max_call_ret", addr, BOUND ? 8'hFF : 8'h00);
    ret = 1'b0;

    do_reset();
    jump = 1'b1; target = 8'h02; step(); jump = 1'b0;
    branch = 1'b1; offset = 8'hFB; step();
    check("br_under", addr, BOUND ? 8'h02 : 8'hFD);
    check("br_under_fault", fault, BOUND ? 1 : 0);
    branch = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
